// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding/stall-flush controller tracking NSTG post-ID stages in a registered table.
// Optional build macro HZ_PERF_CNT_EN adds saturating stall/flush/freeze counters and their ports.
module pipe_hazard_unit #(
    parameter int NSTG     = 3,
    parameter int LOAD_STG = 2,
    parameter int BR_STG   = 1,
    parameter int FW       = $clog2(NSTG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_regwrite,
    input  logic            id_is_load,
    input  logic            br_taken,
    input  logic            dmem_busy,
    output logic            stall,
    output logic            flush_ifid,
    output logic            bubble_idex,
    output logic [NSTG-1:0] kill_vec,
    output logic [FW-1:0]   fwd_a_sel,
    output logic [FW-1:0]   fwd_b_sel,
    output logic            hz_busy
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush,
    output logic [31:0]     perf_freeze
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } entry_t;

    localparam entry_t ENTRY_EMPTY = '0;

    // Index k holds stage k+1: index 0 is EX, index NSTG-1 is WB.
    entry_t          tbl_q [NSTG];
    entry_t          tbl_d [NSTG];
    entry_t          id_entry;

    logic            load_use;
    logic            br_act;
    logic            lu_stall;
    logic            stall_c;
    logic            flush_c;
    logic            bubble_c;
    logic [NSTG-1:0] kill_c;
    logic [FW-1:0]   fwd_a_c;
    logic [FW-1:0]   fwd_b_c;
    logic            found_a;
    logic            found_b;

    function automatic logic fwd_hit(input entry_t e, input logic [4:0] rs,
                                     input logic use_rs, input int idx);
        return use_rs && e.valid && e.regwrite && (e.rd == rs) && (e.rd != 5'd0)
               && (!e.is_load || idx >= LOAD_STG);
    endfunction

    always_comb begin
        id_entry = '{valid:    1'b1,
                     rd:       id_rd,
                     regwrite: id_regwrite,
                     is_load:  id_is_load,
                     rs1:      id_rs1,
                     rs2:      id_rs2,
                     use1:     id_use_rs1,
                     use2:     id_use_rs2};
    end

    // A load still short of LOAD_STG cannot feed the ID instruction next cycle.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LOAD_STG - 1; k++) begin
            if (tbl_q[k].valid && tbl_q[k].is_load && (tbl_q[k].rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == tbl_q[k].rd)) ||
                 (id_use_rs2 && (id_rs2 == tbl_q[k].rd)))) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && id_valid;
    end

    // Scan from the youngest older stage so the most recent producer wins.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int k = 1; k < NSTG; k++) begin
            if (!found_a && fwd_hit(tbl_q[k], tbl_q[0].rs1, tbl_q[0].use1, k)) begin
                found_a = 1'b1;
                fwd_a_c = FW'(k);
            end
            if (!found_b && fwd_hit(tbl_q[k], tbl_q[0].rs2, tbl_q[0].use2, k)) begin
                found_b = 1'b1;
                fwd_b_c = FW'(k);
            end
        end
    end

    // Freeze dominates; a resolved branch then overrides any load-use stall.
    always_comb begin
        br_act   = br_taken && !dmem_busy;
        lu_stall = !dmem_busy && !br_taken && load_use;
        stall_c  = dmem_busy || lu_stall;
        flush_c  = br_act;
        bubble_c = br_act || lu_stall;
        kill_c   = '0;
        for (int k = 0; k < BR_STG - 1; k++) begin
            kill_c[k] = br_act;
        end
    end

    assign stall       = !reset && stall_c;
    assign flush_ifid  = !reset && flush_c;
    assign bubble_idex = !reset && bubble_c;
    assign kill_vec    = reset ? '0 : kill_c;
    assign fwd_a_sel   = reset ? '0 : fwd_a_c;
    assign fwd_b_sel   = reset ? '0 : fwd_b_c;
    assign hz_busy     = stall | flush_ifid | bubble_idex;

    always_comb begin
        tbl_d = tbl_q;
        if (!dmem_busy) begin
            for (int k = NSTG - 1; k >= 1; k--) begin
                tbl_d[k] = kill_c[k-1] ? ENTRY_EMPTY : tbl_q[k-1];
            end
            tbl_d[0] = (id_valid && !stall_c && !bubble_c) ? id_entry : ENTRY_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTG; k++) begin
                tbl_q[k] <= ENTRY_EMPTY;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                tbl_q[k] <= tbl_d[k];
            end
        end
    end

`ifdef HZ_PERF_CNT_EN
    logic [31:0] cnt_stall_q;
    logic [31:0] cnt_flush_q;
    logic [31:0] cnt_freeze_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_stall_q  <= '0;
            cnt_flush_q  <= '0;
            cnt_freeze_q <= '0;
        end else begin
            if (lu_stall && (cnt_stall_q != 32'hFFFF_FFFF)) begin
                cnt_stall_q <= cnt_stall_q + 32'd1;
            end
            if (br_act && (cnt_flush_q != 32'hFFFF_FFFF)) begin
                cnt_flush_q <= cnt_flush_q + 32'd1;
            end
            if (dmem_busy && (cnt_freeze_q != 32'hFFFF_FFFF)) begin
                cnt_freeze_q <= cnt_freeze_q + 32'd1;
            end
        end
    end

    assign perf_stall  = cnt_stall_q;
    assign perf_flush  = cnt_flush_q;
    assign perf_freeze = cnt_freeze_q;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard, forwarding and stall/flush controller for the pipelined RV32 core. It generalises the fixed per-register stall/flush wiring to a pipeline with N post-ID stages. It keeps a registered in-flight table of destination registers and produces:
- forwarding selects for the EX operands
- a load-use interlock
- branch flushes
- a global freeze while data memory is busy

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their stall/flush inputs.

Parameters:
NSTG, 3, number of tracked post-ID stages; stage 1 = EX, stage NSTG = WB (min 2, max 6)
LOAD_STG, 2, stage at whose end load data becomes forwardable (MEM)
BR_STG, 1, stage in which branches/jumps resolve (EX)
FW, $clog2(NSTG), width of a forwarding select

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  5  ID destination register
id_regwrite  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
br_taken  in  1  redirect resolved in stage BR_STG this cycle
dmem_busy  in  1  data memory not ready; freeze whole pipe
stall  out  1  hold PC and IF/ID
flush_ifid  out  1  clear IF/ID
bubble_idex  out  1  load NOP into ID/EX
kill_vec  out  NSTG  bit k-1 invalidates stage k register next edge
fwd_a_sel  out  FW  EX operand A source: 0=RF, j=stage j+1
fwd_b_sel  out  FW  EX operand B source, same encoding
hz_busy  out  1  any stall/flush/freeze active this cycle

Behaviour:
- Interface fixed: single clock `clk`; `reset` synchronous, active-high.
- Table: NSTG entries, each {valid, rd, regwrite, is_load, rs1, rs2, use1, use2}. Registered; all fields cleared on reset.
- Advance (no freeze): entry k+1 <= entry k for k = 1..NSTG-1; entry NSTG drops out.
- Entry 1 load:
  - ID fields, when id_valid & !stall & !flush.
  - Otherwise an invalid bubble.
- Freeze: dmem_busy=1 holds the table unchanged.
  - stall=1; bubble_idex=0; flush_ifid=0; kill_vec=0.
  - br_taken is ignored; the resolving stage keeps asserting it, so it acts on the first non-busy cycle.
- Forwarding (combinational from the table), for EX operand A:
  - Candidate producers: smallest k in 2..NSTG with valid, regwrite, rd==rs1(entry 1), rd!=0, use1.
  - Loads qualify only if k > LOAD_STG.
  - fwd_a_sel = k-1 if found, else 0. Operand B uses rs2/use2.
  - The youngest producer always wins; x0 never forwards.
- Load-use:
  - Condition: id_valid and some entry k (1 <= k < LOAD_STG) with valid, is_load, rd!=0, and rd matching a used ID source.
  - Response: stall=1, bubble_idex=1.
  - Defaults (NSTG=3, LOAD_STG=2): exactly one stall cycle.
- Branch (br_taken & !dmem_busy):
  - flush_ifid=1, bubble_idex=1.
  - kill_vec bits for stages 1..BR_STG-1 set, and those entries invalidated.
  - stall=0: flush overrides a simultaneous load-use stall.
- hz_busy = stall | flush_ifid | bubble_idex.
- Reset:
  - All outputs 0 in the reset cycle, regardless of inputs.
  - Table invalid on the first post-reset cycle.
  - A reset during a freeze or stall clears everything.

Optional Feature:
Macro HZ_PERF_CNT_EN.
- Defined:
  - Adds 32-bit saturating counters, zeroed on reset: cnt_stall (load-use cycles), cnt_flush (branch flushes), cnt_freeze (dmem_busy cycles).
  - Adds output ports perf_stall, perf_flush, perf_freeze (32 each).
- Undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- `add x5,x1,x2` then `sub x6,x5,x3` (defaults) -> when sub is in EX: fwd_a_sel=1, stall=0.
- `add x5`; unrelated instruction; `or x7,x5,x5` -> fwd_a_sel=2 and fwd_b_sel=2 for `or`; then `addi x0,x0,1` followed by a reader of x0 -> fwd_*_sel=0.
- `lw x8,0(x1)` then `add x9,x8,x8` -> exactly 1 cycle with stall=1, bubble_idex=1; next cycle fwd_a_sel=2.
- br_taken=1 in the same cycle as a load-use condition -> flush_ifid=1, bubble_idex=1, stall=0; with BR_STG=2, kill_vec=3'b001.
- dmem_busy high 4 cycles with br_taken=1 -> stall=1 and no flush for 4 cycles; flush on the 5th; table unchanged across the freeze. With HZ_PERF_CNT_EN: perf_freeze=4, perf_flush=1.
- reset asserted mid load-use stall -> next cycle all outputs 0 and table empty; the dependent instruction issues with fwd_*_sel=0.
